// File: rtl/uart_bram_loader_if.sv
// uart_bram_loader_if: write port from the UART program loader to the darkram X-port.
// The master (loader) drives request, strobe, byte enables, address and data;
// the slave (darkram) answers with xdack to retire the pending write.
interface uart_bram_loader_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  xdreq;
   logic                  xwr;
   logic [3:0]            xbe;
   logic [ADDR_WIDTH-1:0] xaddr;
   logic [31:0]           xdata;
   logic                  xdack;

   modport master (output xdreq, output xwr, output xbe, output xaddr, output xdata, input xdack);
   modport slave  (input xdreq, input xwr, input xbe, input xaddr, input xdata, output xdack);
endinterface

// File: rtl/uart_bram_loader.sv
// uart_bram_loader: receives a framed firmware image over an 8N1 UART, packs the payload
// into little-endian 32-bit words and writes them into darkram through the X-port, holding
// the core (cpu_hold) for the duration of the frame.
// Frame: 0xA5, cnt_lo, cnt_hi, then 4*cnt data bytes.
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_bram_loader #(
   parameter int                    CLK_HZ       = 32000000,
   parameter int                    BAUD         = 115200,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    MAX_WORDS    = 1024,
   parameter int                    IDLE_TIMEOUT = 3200000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_i,
   uart_bram_loader_if.master bram,
   output logic               cpu_hold_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam int TW  = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxState_t;
   typedef enum logic [2:0] {F_HDR, F_CNT0, F_CNT1, F_DATA, F_WRITE, F_CSUM, F_DONE} frameState_t;

`ifdef LOADER_CHECKSUM_EN
   localparam frameState_t LAST_NEXT = F_CSUM;
`else
   localparam frameState_t LAST_NEXT = F_DONE;
`endif

   logic          rxMeta_q, rxSync_q, rxPrev_q;
   rxState_t      rxState_q;
   logic [CW-1:0] bitCnt_q;
   logic [2:0]    bitIdx_q;
   logic [7:0]    rxShift_q;
   logic          byteValid_q, frameErr_q;

   frameState_t           frameState_q;
   logic [15:0]           wordCnt_q, wordIdx_q;
   logic [7:0]            cntLo_q;
   logic [1:0]            byteIdx_q;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  timeout, abortReq, hdrAccept;
   logic                  xdreq_q, busy_q, done_q, err_q;
   logic [3:0]            xbe_q;
   logic [ADDR_WIDTH-1:0] xaddr_q;
   logic [31:0]           xdata_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif

   // Bring rx into the clock domain and keep one older sample for start-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
      end
   end

   // 8N1 receiver: centre-samples each bit, flags a good byte or a bad stop bit for one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         rxState_q   <= R_IDLE;
         bitCnt_q    <= '0;
         bitIdx_q    <= '0;
         rxShift_q   <= '0;
         byteValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         byteValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
         case (rxState_q)
            R_IDLE: begin
               if (rxPrev_q && !rxSync_q) begin
                  rxState_q <= R_START;
                  bitCnt_q  <= CW'(DIV / 2);
               end
            end
            R_START: begin
               if (bitCnt_q == '0) begin
                  if (!rxSync_q) begin
                     rxState_q <= R_DATA;
                     bitCnt_q  <= CW'(DIV - 1);
                     bitIdx_q  <= '0;
                  end else begin
                     rxState_q <= R_IDLE;
                  end
               end else begin
                  bitCnt_q <= bitCnt_q - CW'(1);
               end
            end
            R_DATA: begin
               if (bitCnt_q == '0) begin
                  rxShift_q <= {rxSync_q, rxShift_q[7:1]};
                  bitCnt_q  <= CW'(DIV - 1);
                  bitIdx_q  <= bitIdx_q + 3'd1;
                  if (bitIdx_q == 3'd7) rxState_q <= R_STOP;
               end else begin
                  bitCnt_q <= bitCnt_q - CW'(1);
               end
            end
            R_STOP: begin
               if (bitCnt_q == '0) begin
                  if (rxSync_q) byteValid_q <= 1'b1;
                  else          frameErr_q  <= 1'b1;
                  rxState_q <= R_IDLE;
               end else begin
                  bitCnt_q <= bitCnt_q - CW'(1);
               end
            end
            default: rxState_q <= R_IDLE;
         endcase
      end
   end

   assign hdrAccept = (frameState_q == F_HDR) && byteValid_q && (rxShift_q == 8'hA5);

   // Inter-byte watchdog: reloads on every byte (a byte arriving on the expiry cycle wins)
   always_comb begin
      timer_d = timer_q;
      timeout = 1'b0;
      if (byteValid_q || frameState_q == F_HDR) begin
         timer_d = TW'(IDLE_TIMEOUT - 1);
      end else if (timer_q == '0) begin
         timeout = (frameState_q != F_DONE);
      end else begin
         timer_d = timer_q - TW'(1);
      end
   end

   // Conditions that kill the frame; a byte landing while a write is still pending is an overrun
   always_comb begin
      abortReq = timeout;
      if (byteValid_q) begin
         case (frameState_q)
            F_CNT1:  abortReq = ({rxShift_q, cntLo_q} > 16'(MAX_WORDS));
            F_WRITE: abortReq = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            F_CSUM:  abortReq = (rxShift_q != csum_q);
`endif
            default: abortReq = 1'b0;
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Running XOR over the count bytes and every payload byte of the current frame
   always_ff @(posedge clk) begin
      if (reset || hdrAccept) begin
         csum_q <= '0;
      end else if (byteValid_q && (frameState_q == F_CNT0 || frameState_q == F_CNT1 ||
                                   frameState_q == F_DATA)) begin
         csum_q <= csum_q ^ rxShift_q;
      end
   end
`endif

   // Frame sequencer: header, word count, payload assembly and the X-port write handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         frameState_q <= F_HDR;
         wordCnt_q    <= '0;
         wordIdx_q    <= '0;
         cntLo_q      <= '0;
         byteIdx_q    <= '0;
         timer_q      <= TW'(IDLE_TIMEOUT - 1);
         xdreq_q      <= 1'b0;
         xbe_q        <= 4'h0;
         xaddr_q      <= '0;
         xdata_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         timer_q <= timer_d;
         done_q  <= 1'b0;
         if (frameErr_q) err_q <= 1'b1;
         if (abortReq) begin
            err_q        <= 1'b1;
            frameState_q <= F_HDR;
            xdreq_q      <= 1'b0;
            xbe_q        <= 4'h0;
            busy_q       <= 1'b0;
            wordIdx_q    <= '0;
         end else begin
            case (frameState_q)
               F_HDR: begin
                  if (hdrAccept) begin
                     frameState_q <= F_CNT0;
                     err_q        <= 1'b0;
                     busy_q       <= 1'b1;
                  end
               end
               F_CNT0: begin
                  if (byteValid_q) begin
                     cntLo_q      <= rxShift_q;
                     frameState_q <= F_CNT1;
                  end
               end
               F_CNT1: begin
                  if (byteValid_q) begin
                     wordCnt_q    <= {rxShift_q, cntLo_q};
                     byteIdx_q    <= '0;
                     frameState_q <= ({rxShift_q, cntLo_q} == 16'd0) ? F_DONE : F_DATA;
                  end
               end
               F_DATA: begin
                  if (byteValid_q) begin
                     xdata_q[8*byteIdx_q +: 8] <= rxShift_q;
                     byteIdx_q <= byteIdx_q + 2'd1;
                     if (byteIdx_q == 2'd3) begin
                        xdreq_q      <= 1'b1;
                        xbe_q        <= 4'hf;
                        xaddr_q      <= BASE_ADDR + ADDR_WIDTH'({wordIdx_q, 2'b00});
                        frameState_q <= F_WRITE;
                     end
                  end
               end
               F_WRITE: begin
                  if (bram.xdack) begin
                     xdreq_q      <= 1'b0;
                     xbe_q        <= 4'h0;
                     wordIdx_q    <= wordIdx_q + 16'd1;
                     frameState_q <= (wordIdx_q + 16'd1 == wordCnt_q) ? LAST_NEXT : F_DATA;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               F_CSUM: begin
                  if (byteValid_q) frameState_q <= F_DONE;
               end
`endif
               F_DONE: begin
                  done_q       <= 1'b1;
                  busy_q       <= 1'b0;
                  wordIdx_q    <= '0;
                  frameState_q <= F_HDR;
               end
               default: frameState_q <= F_HDR;
            endcase
         end
      end
   end

   assign bram.xdreq = xdreq_q;
   assign bram.xwr   = xdreq_q;
   assign bram.xbe   = xbe_q;
   assign bram.xaddr = xaddr_q;
   assign bram.xdata = xdata_q;
   assign cpu_hold_o = busy_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
endmodule

// File: tb/tb_uart_bram_loader.sv
// tb_uart_bram_loader: directed frames over a serial rx line, an X-port responder, and a
// frame-level model that predicts the writes, done pulse and error flag of each frame.
module tb_uart_bram_loader;
   localparam int CLK_HZ       = 1600;
   localparam int BAUD         = 100;
   localparam int DIV          = CLK_HZ / BAUD;
   localparam int IDLE_TIMEOUT = 400;
   localparam int MAX_WORDS    = 1024;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset;
   logic rx;
   logic cpuHold, busy, done, err;
   logic ackEnable;

   int   assertCount = 0;
   int   failCount   = 0;
   int   doneCount   = 0;
   int   writeCount  = 0;
   int   reqCycles   = 0;
   int   doneBase, writeBase, reqBase;
   bit   expDone, expErr;
   logic prevDone = 1'b0, prevReq = 1'b0, prevAck = 1'b0;
   logic [31:0] prevAddr = '0, prevData = '0;

   logic [7:0] txQ[$];
   wr_t        expQ[$];
   wr_t        actQ[$];

   uart_bram_loader_if #(.ADDR_WIDTH(32)) bramIf ();

   uart_bram_loader #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(32), .BASE_ADDR(32'h0),
      .MAX_WORDS(MAX_WORDS), .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .rx_i(rx), .bram(bramIf),
      .cpu_hold_o(cpuHold), .busy_o(busy), .done_o(done), .err_o(err)
   );

   // Free-running system clock
   always #5 clk = ~clk;

   // Hard stop in case a wait never completes
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: time limit reached, failures so far %0d", failCount);
      $fatal(1, "[TB] simulation aborted");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // darkram stand-in: answers a request with xdack one cycle after it appears
   initial begin
      bramIf.xdack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bramIf.xdack = ackEnable && bramIf.xdreq && !bramIf.xdack;
      end
   end

   // Per-cycle checks of port relations and of every accepted write against the model
   always @(negedge clk) begin
      checkOutput("cpu_hold vs busy", cpuHold, busy);
      checkOutput("xwr vs xdreq", bramIf.xwr, bramIf.xdreq);
      checkOutput("xbe", bramIf.xbe, bramIf.xdreq ? 4'hf : 4'h0);
      if (done) begin
         doneCount++;
         checkOutput("busy low with done", busy, 1'b0);
         checkOutput("done single cycle", prevDone, 1'b0);
      end
      if (bramIf.xdreq) reqCycles++;
      if (bramIf.xdreq && prevReq && !prevAck) begin
         checkOutput("xaddr stable", bramIf.xaddr, prevAddr);
         checkOutput("xdata stable", bramIf.xdata, prevData);
      end
      if (bramIf.xdreq && bramIf.xdack) begin
         wr_t e;
         writeCount++;
         actQ.push_back('{addr: bramIf.xaddr, data: bramIf.xdata});
         checkOutput("write was predicted", (expQ.size() > 0), 1'b1);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("write addr", bramIf.xaddr, e.addr);
            checkOutput("write data", bramIf.xdata, e.data);
         end
      end
      prevDone = done;
      prevReq  = bramIf.xdreq;
      prevAck  = bramIf.xdack;
      prevAddr = bramIf.xaddr;
      prevData = bramIf.xdata;
   end

   // Frame-level model: find the header, read the count, cut the payload into words
   task automatic modelFrame(output bit mDone, output bit mErr);
      int i;
      int cnt;
      logic [7:0] x;
      wr_t w;
      mDone = 1'b0;
      mErr  = 1'b0;
      i = 0;
      while (i < txQ.size() && txQ[i] != 8'hA5) i++;
      if (i >= txQ.size()) return;
      if (i + 2 >= txQ.size()) begin
         mErr = 1'b1;
         return;
      end
      cnt = int'(txQ[i+1]) + 256 * int'(txQ[i+2]);
      x   = txQ[i+1] ^ txQ[i+2];
      if (cnt > MAX_WORDS) begin
         mErr = 1'b1;
         return;
      end
      i += 3;
      for (int k = 0; k < cnt; k++) begin
         if (i + 4 > txQ.size()) begin
            mErr = 1'b1;
            return;
         end
         w.addr = 32'(4 * k);
         w.data = {txQ[i+3], txQ[i+2], txQ[i+1], txQ[i]};
         x = x ^ txQ[i] ^ txQ[i+1] ^ txQ[i+2] ^ txQ[i+3];
         expQ.push_back(w);
         i += 4;
      end
`ifdef LOADER_CHECKSUM_EN
      if (cnt != 0) begin
         if (i >= txQ.size() || txQ[i] != x) begin
            mErr = 1'b1;
            return;
         end
      end
`endif
      mDone = 1'b1;
   endtask

   task automatic pushBytes(input logic [127:0] v, input int n);
      txQ.delete();
      for (int i = 0; i < n; i++) txQ.push_back(v[(n-1-i)*8 +: 8]);
   endtask

   task automatic addChecksum(input int start);
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] x = 8'h00;
      for (int i = start; i < txQ.size(); i++) x ^= txQ[i];
      txQ.push_back(x);
`else
      if (start < 0) txQ.delete();
`endif
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = 1'b1;
      repeat (3 * DIV) @(negedge clk);
   endtask

   task automatic sendGlitch();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2 * DIV) @(negedge clk);
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < txQ.size(); i++) sendByte(txQ[i]);
   endtask

   task automatic startFrame();
      modelFrame(expDone, expErr);
      doneBase  = doneCount;
      writeBase = writeCount;
      reqBase   = reqCycles;
   endtask

   task automatic finishFrame(input string name, input int settle);
      repeat (settle) @(negedge clk);
      checkOutput({name, " done count"}, doneCount - doneBase, expDone);
      checkOutput({name, " err"}, err, expErr);
      checkOutput({name, " pending modelled writes"}, expQ.size(), 0);
      checkOutput({name, " busy released"}, busy, 1'b0);
      checkOutput({name, " cpu_hold released"}, cpuHold, 1'b0);
   endtask

   initial begin
      rx        = 1'b1;
      reset     = 1'b1;
      ackEnable = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset xdreq", bramIf.xdreq, 1'b0);
      checkOutput("reset xaddr", bramIf.xaddr, 32'h0);
      checkOutput("reset xdata", bramIf.xdata, 32'h0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset err", err, 1'b0);

      // Two-word frame with prompt acknowledges
      pushBytes(88'hA5_02_00_11_22_33_44_55_66_77_88, 11);
      addChecksum(1);
      startFrame();
      applyStimulus();
      finishFrame("t1", 50);
      checkOutput("t1 write count", writeCount - writeBase, 2);
      checkOutput("t1 word0 data", (actQ.size() > 0) ? actQ[0].data : 32'hx, 32'h44332211);
      checkOutput("t1 word1 addr", (actQ.size() > 1) ? actQ[1].addr : 32'hx, 32'h4);
      checkOutput("t1 word1 data", (actQ.size() > 1) ? actQ[1].data : 32'hx, 32'h88776655);

      // Start-bit glitch and a non-header byte ahead of a valid frame
      sendGlitch();
      pushBytes(96'h00_A5_02_00_AA_BB_CC_DD_01_02_03_04, 12);
      addChecksum(2);
      startFrame();
      applyStimulus();
      finishFrame("t2", 50);
      checkOutput("t2 word0 data", (actQ.size() > 2) ? actQ[2].data : 32'hx, 32'hDDCCBBAA);
      checkOutput("t2 word1 addr", (actQ.size() > 3) ? actQ[3].addr : 32'hx, 32'h4);

      // Header and count, then the line goes quiet
      pushBytes(24'hA5_01_00, 3);
      startFrame();
      applyStimulus();
      checkOutput("t3 cpu_hold during frame", cpuHold, 1'b1);
      finishFrame("t3", IDLE_TIMEOUT + 200);
      checkOutput("t3 err literal", err, 1'b1);
      checkOutput("t3 no request", reqCycles - reqBase, 0);

      // Oversized count, then a good frame clears the error
      pushBytes(24'hA5_FF_FF, 3);
      startFrame();
      applyStimulus();
      finishFrame("t4a", 50);
      checkOutput("t4a no request", reqCycles - reqBase, 0);
      pushBytes(56'hA5_01_00_DE_AD_BE_EF, 7);
      addChecksum(1);
      startFrame();
      applyStimulus();
      finishFrame("t4b", 50);
      checkOutput("t4b err cleared", err, 1'b0);
      checkOutput("t4b word data", (actQ.size() > 0) ? actQ[actQ.size()-1].data : 32'hx,
                  32'hEFBEADDE);

      // Write never acknowledged, next byte overruns it
      ackEnable = 1'b0;
      writeBase = writeCount;
      pushBytes(56'hA5_02_00_11_22_33_44, 7);
      applyStimulus();
      checkOutput("t5 request held", bramIf.xdreq, 1'b1);
      checkOutput("t5 held data", bramIf.xdata, 32'h44332211);
      sendByte(8'h55);
      checkOutput("t5 overrun err", err, 1'b1);
      checkOutput("t5 request dropped", bramIf.xdreq, 1'b0);
      checkOutput("t5 busy dropped", busy, 1'b0);
      ackEnable = 1'b1;
      doneBase = doneCount;
      pushBytes(32'hA5_01_00_11, 4);
      applyStimulus();
      checkOutput("t5 busy mid-frame", busy, 1'b1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("t5 reset busy", busy, 1'b0);
      checkOutput("t5 reset err", err, 1'b0);
      checkOutput("t5 reset xdreq", bramIf.xdreq, 1'b0);
      pushBytes(24'h22_33_44, 3);
      applyStimulus();
      repeat (20) @(negedge clk);
      checkOutput("t5 no writes", writeCount - writeBase, 0);
      checkOutput("t5 no done", doneCount - doneBase, 0);
      checkOutput("t5 idle after reset", busy, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      // Matching and mismatching checksum bytes
      pushBytes(64'hA5_01_00_01_02_03_04_05, 8);
      startFrame();
      applyStimulus();
      finishFrame("t6a", 50);
      checkOutput("t6a done literal", doneCount - doneBase, 1);
      pushBytes(64'hA5_01_00_01_02_03_04_06, 8);
      startFrame();
      applyStimulus();
      finishFrame("t6b", 50);
      checkOutput("t6b err literal", err, 1'b1);
      checkOutput("t6b write kept", writeCount - writeBase, 1);
      checkOutput("t6b word data", (actQ.size() > 0) ? actQ[actQ.size()-1].data : 32'hx,
                  32'h04030201);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
